// File: rtl/mux_rr_sel_gen.sv
// rtl/mux_rr_sel_gen.sv - round-robin select generator with bounded bursts for a 3-input mux
module mux_rr_sel_gen #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic             ready,
    output logic [1:0]       sel,
    output logic [2:0]       grant,
    output logic             valid,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [1:0]       SEL_IDLE = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic       req_cur;
    logic       beat;
    logic       release_grant;
    logic [1:0] winner_idle;
    logic [1:0] winner_rel;

    // Candidates are examined at ptr+1, ptr+2, ptr (mod 3); 2'b11 means no requester.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] w;
        w = SEL_IDLE;
        case (p)
            2'd0:    w = r[1] ? 2'd1 : r[2] ? 2'd2 : r[0] ? 2'd0 : SEL_IDLE;
            2'd1:    w = r[2] ? 2'd2 : r[0] ? 2'd0 : r[1] ? 2'd1 : SEL_IDLE;
            default: w = r[0] ? 2'd0 : r[1] ? 2'd1 : r[2] ? 2'd2 : SEL_IDLE;
        endcase
        return w;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] s);
        logic [2:0] g;
        g = 3'b000;
        case (s)
            2'd0:    g = 3'b001;
            2'd1:    g = 3'b010;
            2'd2:    g = 3'b100;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

    always_comb begin
        req_cur = 1'b0;
        case (sel_q)
            2'd0:    req_cur = req[0];
            2'd1:    req_cur = req[1];
            2'd2:    req_cur = req[2];
            default: req_cur = 1'b0;
        endcase
    end

    assign valid         = (state_q == S_GRANT) && req_cur;
    assign beat          = valid && ready;
    assign release_grant = !req_cur || (beat && (beat_cnt_q == CNT_LAST));
    assign winner_idle   = rr_pick(req, ptr_q);
    assign winner_rel    = rr_pick(req, sel_q);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        ptr_d      = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    state_d    = S_GRANT;
                    sel_d      = winner_idle;
                    grant_d    = onehot(winner_idle);
                    beat_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (release_grant) begin
                    // Re-pick relative to the releasing source so grants chain with no bubble.
                    ptr_d      = sel_q;
                    beat_cnt_d = '0;
                    if (winner_rel != SEL_IDLE) begin
                        state_d = S_GRANT;
                        sel_d   = winner_rel;
                        grant_d = onehot(winner_rel);
                    end else begin
                        state_d = S_IDLE;
                        sel_d   = SEL_IDLE;
                        grant_d = 3'b000;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                sel_d      = SEL_IDLE;
                grant_d    = 3'b000;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= SEL_IDLE;
            grant_q    <= 3'b000;
            beat_cnt_q <= '0;
            ptr_q      <= 2'd2;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign sel      = sel_q;
    assign grant    = grant_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mux_rr_sel_gen.sv
// tb/tb_mux_rr_sel_gen.sv - directed and random stimulus against an integer reference model
module tb_mux_rr_sel_gen;

    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic             ready;
    logic [1:0]       sel;
    logic [2:0]       grant;
    logic             valid;
    logic [CNT_W-1:0] beat_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: m_cur is the granted source index, 3 when idle.
    int m_cur;
    int m_ptr;
    int m_cnt;

    mux_rr_sel_gen #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ready    (ready),
        .sel      (sel),
        .grant    (grant),
        .valid    (valid),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [2:0] r, input int p);
        for (int k = 1; k <= 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return 3;
    endfunction

    task automatic step(input logic r_in, input logic [2:0] q_in, input logic rdy_in);
        int  exp_grant;
        bit  exp_valid;
        bit  is_beat;
        @(negedge clk);
        rst   = r_in;
        req   = q_in;
        ready = rdy_in;
        #1;
        exp_grant = (m_cur == 3) ? 0 : (1 << m_cur);
        exp_valid = (m_cur != 3) && q_in[m_cur];
        check_eq("sel",      8'(sel),      8'(m_cur));
        check_eq("grant",    8'(grant),    8'(exp_grant));
        check_eq("valid",    8'(valid),    8'(exp_valid));
        check_eq("beat_cnt", 8'(beat_cnt), 8'(m_cnt));
        if (r_in) begin
            m_cur = 3; m_ptr = 2; m_cnt = 0;
        end else if (m_cur == 3) begin
            m_cur = model_pick(q_in, m_ptr);
            m_cnt = 0;
        end else begin
            is_beat = exp_valid && rdy_in;
            if (!q_in[m_cur] || (is_beat && m_cnt == MAX_BURST - 1)) begin
                m_ptr = m_cur;
                m_cur = model_pick(q_in, m_ptr);
                m_cnt = 0;
            end else if (is_beat) begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        logic [2:0] rq;
        logic [5:0] bp;
        rst = 1'b1; req = 3'b111; ready = 1'b1;
        @(posedge clk);
        m_cur = 3; m_ptr = 2; m_cnt = 0;

        repeat (2) step(1'b1, 3'b111, 1'b1);
        repeat (14) step(1'b0, 3'b111, 1'b1);
        repeat (2) step(1'b0, 3'b000, 1'b1);

        repeat (3) step(1'b0, 3'b010, 1'b1);
        repeat (2) step(1'b0, 3'b000, 1'b1);

        step(1'b0, 3'b010, 1'b0);
        bp = 6'b111001;
        for (int i = 0; i < 6; i++) step(1'b0, 3'b010, bp[i]);
        repeat (2) step(1'b0, 3'b000, 1'b1);

        repeat (11) step(1'b0, 3'b100, 1'b1);
        repeat (2) step(1'b0, 3'b000, 1'b1);

        repeat (3) step(1'b0, 3'b100, 1'b1);
        step(1'b1, 3'b101, 1'b1);
        repeat (6) step(1'b0, 3'b101, 1'b1);

        rq = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 99) == 0), rq, 1'($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
